// File: rtl/fcp6_pkg.sv
// Shared definitions for the FCP6 receive path.
//   ctrl_e      : 2-bit lane control encodings
//   rx_state_e  : receiver FSM states
//   FRAME_SYMS  : DATA symbols in a well-formed frame
//   CNT_SAT     : saturation value of the symbol counter (one past a full frame)
//   BCAST_ADDR  : header address accepted by every node
package fcp6_pkg;

  typedef enum logic [1:0] {
    CTRL_IDLE  = 2'b00,
    CTRL_START = 2'b01,
    CTRL_DATA  = 2'b10,
    CTRL_END   = 2'b11
  } ctrl_e;

  typedef enum logic {
    RX_IDLE,
    RX_RECV
  } rx_state_e;

  localparam int         FRAME_SYMS = 8;
  localparam logic [3:0] CNT_SAT    = 4'd9;
  localparam logic [3:0] BCAST_ADDR = 4'hF;

endpackage

// File: rtl/fcp6_rx_if.sv
// FCP6 link bundle between a sender (master) and the receiver (slave).
//   ctrl, data       : lane symbols driven by the sender
//   ack              : one-cycle frame-accepted pulse back to the sender
//   busy             : receiver is inside a frame
//   rx_valid         : one-cycle pulse, new rx_header/rx_data loaded
//   rx_header/rx_data: last accepted frame contents (held)
//   rx_err           : one-cycle framing error / timeout pulse
interface fcp6_rx_if;
  logic [1:0] ctrl;
  logic [1:0] data;
  logic       ack;
  logic       busy;
  logic       rx_valid;
  logic [7:0] rx_header;
  logic [7:0] rx_data;
  logic       rx_err;

  modport master (
    output ctrl, data,
    input  ack, busy, rx_valid, rx_header, rx_data, rx_err
  );

  modport slave (
    input  ctrl, data,
    output ack, busy, rx_valid, rx_header, rx_data, rx_err
  );
endinterface

// File: rtl/fcp6_deser.sv
// 16-bit symbol deserialiser: shifts 2-bit symbols in MSB pair first and
// counts them with a 4-bit counter that saturates at CNT_SAT, so any
// overlong frame stays distinguishable from a full one.
//   clk, rst     : clock, synchronous active-high reset
//   clear_i      : zero the shift register and the counter
//   shift_en_i   : shift sym_i in and bump the counter
//   sym_i        : incoming 2-bit symbol
//   shreg_o      : {header, data} once a full frame is in
//   count_o      : symbols received since the last clear
module fcp6_deser
  import fcp6_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        shift_en_i,
  input  logic [1:0]  sym_i,
  output logic [15:0] shreg_o,
  output logic [3:0]  count_o
);

  logic [15:0] shreg_q, shreg_d;
  logic [3:0]  count_q, count_d;

  always_comb begin
    shreg_d = shreg_q;
    count_d = count_q;
    if (clear_i) begin
      shreg_d = '0;
      count_d = '0;
    end else if (shift_en_i) begin
      shreg_d = {shreg_q[13:0], sym_i};
      if (count_q != CNT_SAT) begin
        count_d = count_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      count_q <= '0;
    end else begin
      shreg_q <= shreg_d;
      count_q <= count_d;
    end
  end

  assign shreg_o = shreg_q;
  assign count_o = count_q;

endmodule

// File: rtl/fcp6_rx.sv
// FCP6 link receiver. Collects START / 8x DATA / END frames, checks length
// and address (ADDR or broadcast), and reports the result one cycle after
// END: ack + rx_valid with the new header/data, or rx_err. A stall of
// TIMEOUT consecutive IDLE symbols inside a frame, or a START inside a
// frame, also raises rx_err.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fcp6_rx_if slave modport (lane inputs, status outputs)
module fcp6_rx
  import fcp6_pkg::*;
#(
  parameter logic [3:0] ADDR    = 4'h3,
  parameter int         TIMEOUT = 16
) (
  input  logic      clk,
  input  logic      rst,
  fcp6_rx_if.slave  bus
);

  localparam int            IW      = $clog2(TIMEOUT + 1);
  // The IDLE that takes the run length to TIMEOUT is the aborting one.
  localparam logic [IW-1:0] TO_LAST = IW'(TIMEOUT - 1);

  ctrl_e         ctrl;
  rx_state_e     state_q;
  logic [IW-1:0] idle_cnt_q;
  logic          ack_q, valid_q, err_q;
  logic [7:0]    hdr_q, data_q;

  logic [15:0]   shreg;
  logic [3:0]    count;
  logic          deser_clear, deser_shift, addr_ok, full_frame;

  assign ctrl = ctrl_e'(bus.ctrl);

  // START always begins a fresh frame, whether from IDLE or as a restart.
  assign deser_clear = (ctrl == CTRL_START);
  assign deser_shift = (state_q == RX_RECV) && (ctrl == CTRL_DATA);

  fcp6_deser u_deser (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (deser_clear),
    .shift_en_i(deser_shift),
    .sym_i     (bus.data),
    .shreg_o   (shreg),
    .count_o   (count)
  );

  assign full_frame = (count == 4'(FRAME_SYMS));
  assign addr_ok    = (shreg[15:12] == ADDR) || (shreg[15:12] == BCAST_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RX_IDLE;
      idle_cnt_q <= '0;
      ack_q      <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      hdr_q      <= '0;
      data_q     <= '0;
    end else begin
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (ctrl == CTRL_START) begin
            state_q    <= RX_RECV;
            idle_cnt_q <= '0;
          end
        end
        RX_RECV: begin
          case (ctrl)
            CTRL_DATA: idle_cnt_q <= '0;
            CTRL_IDLE: begin
              if (idle_cnt_q == TO_LAST) begin
                err_q      <= 1'b1;
                state_q    <= RX_IDLE;
                idle_cnt_q <= '0;
              end else begin
                idle_cnt_q <= idle_cnt_q + IW'(1);
              end
            end
            CTRL_START: begin
              err_q      <= 1'b1;
              idle_cnt_q <= '0;
            end
            CTRL_END: begin
              state_q    <= RX_IDLE;
              idle_cnt_q <= '0;
              if (!full_frame) begin
                err_q <= 1'b1;
              end else if (addr_ok) begin
                ack_q   <= 1'b1;
                valid_q <= 1'b1;
                hdr_q   <= shreg[15:8];
                data_q  <= shreg[7:0];
              end
            end
            default: ;
          endcase
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.rx_valid  = valid_q;
  assign bus.rx_err    = err_q;
  assign bus.busy      = (state_q == RX_RECV);
  assign bus.rx_header = hdr_q;
  assign bus.rx_data   = data_q;

endmodule

// File: tb/tb_fcp6_rx.sv
module tb_fcp6_rx;

  localparam logic [3:0] A  = 4'h3;
  localparam int         TO = 16;

  localparam logic [1:0] C_IDLE  = 2'b00;
  localparam logic [1:0] C_START = 2'b01;
  localparam logic [1:0] C_DATA  = 2'b10;
  localparam logic [1:0] C_END   = 2'b11;

  localparam int K_ACK = 1;
  localparam int K_ERR = 2;

  typedef struct {
    int         kind;
    logic [7:0] hdr;
    logic [7:0] dat;
    int         stamp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  fcp6_rx_if bus ();

  fcp6_rx #(.ADDR(A), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model (frame-level) ----------------
  exp_t       expq[$];
  bit         exp_busy[int];
  bit         m_in = 1'b0;
  int         m_idle = 0;
  logic [1:0] m_syms[$];

  function automatic void push_exp(int kind, logic [7:0] h, logic [7:0] d, int stamp);
    exp_t e;
    e.kind = kind; e.hdr = h; e.dat = d; e.stamp = stamp;
    expq.push_back(e);
  endfunction

  function automatic void model_reset();
    m_in = 1'b0;
    m_idle = 0;
    m_syms.delete();
  endfunction

  function automatic void model_step(logic [1:0] c, logic [1:0] d, int stamp);
    logic [15:0] v;
    if (!m_in) begin
      if (c == C_START) begin
        m_in = 1'b1;
        m_idle = 0;
        m_syms.delete();
      end
    end else begin
      case (c)
        C_DATA: begin
          m_syms.push_back(d);
          m_idle = 0;
        end
        C_IDLE: begin
          m_idle++;
          if (m_idle == TO) begin
            push_exp(K_ERR, 8'h00, 8'h00, stamp);
            m_in = 1'b0;
          end
        end
        C_START: begin
          push_exp(K_ERR, 8'h00, 8'h00, stamp);
          m_syms.delete();
          m_idle = 0;
        end
        default: begin
          m_in = 1'b0;
          if (m_syms.size() == 8) begin
            v = 16'h0;
            foreach (m_syms[i]) v = v * 16'd4 + 16'(m_syms[i]);
            if (v[15:12] == A || v[15:12] == 4'hF)
              push_exp(K_ACK, v[15:8], v[7:0], stamp);
          end else begin
            push_exp(K_ERR, 8'h00, 8'h00, stamp);
          end
        end
      endcase
    end
    exp_busy[stamp] = m_in;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT raises ack/rx_valid/rx_err.
  initial begin : monitor
    logic       r;
    logic [7:0] held_h, held_d;
    exp_t       e;
    held_h = 8'h00;
    held_d = 8'h00;
    forever begin
      @(posedge clk);
      r = rst;
      #1;
      if (r) begin
        chk("reset_outputs",
            {14'h0, bus.ack, bus.rx_valid, bus.rx_err, bus.busy, bus.rx_header, bus.rx_data},
            32'h0);
        held_h = 8'h00;
        held_d = 8'h00;
        if (exp_busy.exists(cyc)) exp_busy.delete(cyc);
      end else begin
        if (bus.ack || bus.rx_valid || bus.rx_err) begin
          if (expq.size() == 0) begin
            chk("unexpected_event", {29'h0, bus.ack, bus.rx_valid, bus.rx_err}, 32'h0);
          end else begin
            e = expq.pop_front();
            chk("event_kind", {29'h0, bus.ack, bus.rx_valid, bus.rx_err},
                (e.kind == K_ACK) ? 32'h6 : 32'h1);
            chk("event_cycle", cyc, e.stamp);
            if (e.kind == K_ACK) begin
              held_h = e.hdr;
              held_d = e.dat;
              $display("[cyc %0d] ack  hdr=%h data=%h", cyc, bus.rx_header, bus.rx_data);
            end else begin
              $display("[cyc %0d] rx_err", cyc);
            end
          end
        end
        chk("held_regs", {16'h0, bus.rx_header, bus.rx_data}, {16'h0, held_h, held_d});
        if (exp_busy.exists(cyc)) begin
          chk("busy", {31'h0, bus.busy}, {31'h0, exp_busy[cyc]});
          exp_busy.delete(cyc);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(logic [1:0] c, logic [1:0] d);
    @(negedge clk);
    rst = 1'b0;
    bus.ctrl = c;
    bus.data = d;
    model_step(c, d, cyc + 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.ctrl = C_IDLE;
    bus.data = 2'b00;
    model_reset();
    exp_busy[cyc + 1] = 1'b0;
  endtask

  task automatic idles(int n);
    for (int i = 0; i < n; i++) send(C_IDLE, 2'($urandom));
  endtask

  task automatic datas(int n);
    for (int i = 0; i < n; i++) send(C_DATA, 2'($urandom));
  endtask

  // Full frame; optionally stall `gap` IDLEs before DATA symbol `gap_at`.
  task automatic frame(logic [7:0] h, logic [7:0] dd, int gap_at, int gap);
    logic [15:0] w;
    w = {h, dd};
    send(C_START, 2'($urandom));
    for (int i = 0; i < 8; i++) begin
      if (i == gap_at) idles(gap);
      send(C_DATA, w[15 - 2*i -: 2]);
    end
    send(C_END, 2'($urandom));
  endtask

  initial begin : stim
    logic [3:0] nib;
    int         mode;
    bus.ctrl = C_IDLE;
    bus.data = 2'b00;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    idles(2);

    // Directed cases
    frame(8'h36, 8'hAF, -1, 0);              // valid, own address
    idles(2);
    frame(8'hF1, 8'h5A, -1, 0);              // broadcast
    idles(1);
    frame(8'h51, 8'h77, -1, 0);              // address mismatch, ignored
    idles(2);
    send(C_START, 2'd0); datas(6); send(C_END, 2'd0);   // short
    idles(1);
    send(C_START, 2'd0); datas(9); send(C_END, 2'd0);   // overlong
    idles(1);
    frame(8'h3C, 8'h12, 4, 3);               // short stall, accepted
    idles(1);
    send(C_START, 2'd0); datas(4); idles(TO);           // timeout
    datas(2); send(C_END, 2'd0);                         // ignored while idle
    idles(1);
    send(C_START, 2'd0); datas(5);                       // restart mid-frame
    frame(8'h3E, 8'h99, -1, 0);
    idles(1);
    send(C_START, 2'd0); datas(3); do_reset();           // reset mid-frame
    idles(1);
    frame(8'h30, 8'h01, -1, 0);
    frame(8'hF2, 8'hC3, -1, 0);                          // back-to-back
    frame(8'h34, 8'h56, -1, 0);
    idles(2);

    // Randomised traffic
    for (int it = 0; it < 300; it++) begin
      mode = $urandom_range(0, 19);
      case ($urandom_range(0, 3))
        0:       nib = A;
        1:       nib = 4'hF;
        default: nib = 4'($urandom);
      endcase
      if (mode < 12) begin
        if ($urandom_range(0, 4) == 0)
          frame({nib, 4'($urandom)}, 8'($urandom), $urandom_range(0, 7), $urandom_range(1, 20));
        else
          frame({nib, 4'($urandom)}, 8'($urandom), -1, 0);
      end else if (mode < 15) begin
        send(C_START, 2'($urandom));
        datas($urandom_range(0, 11));
        send(C_END, 2'($urandom));
      end else if (mode < 18) begin
        for (int k = 0; k < int'($urandom_range(1, 10)); k++)
          send(2'($urandom), 2'($urandom));
      end else if (mode == 18) begin
        do_reset();
      end else begin
        idles($urandom_range(1, 5));
      end
    end

    idles(TO + 2);
    chk("scoreboard_drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fcp6_rx.md
Name: fcp6_rx

Overview:
- Receive-side end of the FCP6 serial link: accepts frames driven on the 2-bit ctrl / 2-bit data lanes.
- Deserialises each frame into an 8-bit header and an 8-bit data byte, checks framing and address, and returns a one-cycle ack to the sender.
- Sits on the slave side of the link and presents each accepted frame to local logic through a valid pulse plus held registers.

Parameters:
- ADDR, 4'h3, node address matched against header[7:4]; 4'hF is always accepted as broadcast.
- TIMEOUT, 16, max consecutive IDLE cycles tolerated inside a frame before abort.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- ctrl  in  2  frame control: 00 IDLE, 01 START, 10 DATA, 11 END.
- data  in  2  payload symbol, valid only when ctrl=DATA.
- ack  out  1  one-cycle pulse: frame accepted.
- busy  out  1  high while a frame is being received.
- rx_valid  out  1  one-cycle pulse coincident with ack.
- rx_header  out  8  last accepted header, held until the next accept.
- rx_data  out  8  last accepted data byte, held until the next accept.
- rx_err  out  1  one-cycle pulse: framing error or timeout.

Behaviour:
- Reset (rst sampled high at a clk edge): all outputs 0, state IDLE, symbol count 0, idle counter 0. Reset mid-frame discards the frame silently, with no ack and no rx_err.
- Frame format: START (data ignored), then exactly 8 DATA symbols, MSB pair first (header[7:6], header[5:4], header[3:2], header[1:0], data[7:6] … data[1:0]), then END (data ignored).
- States:
  - IDLE: busy=0. START -> RECV and clear the count. DATA or END in IDLE is ignored, with no error.
  - RECV: busy=1.
    - DATA: shift the symbol into a 16-bit register; count++ saturating at 9; clear the idle counter.
    - IDLE: hold; idle counter++. When the counter reaches TIMEOUT, pulse rx_err, then go to IDLE.
    - START: abort the current frame, pulse rx_err, restart RECV with count 0.
    - END: evaluate the frame, then go to IDLE.
- END evaluation, with outputs registered in the cycle after END:
  - count==8 and (header[7:4]==ADDR or 4'hF): ack=1 and rx_valid=1 for one cycle; rx_header and rx_data load.
  - count==8 with an address mismatch: frame ignored; no ack, no rx_valid, no rx_err.
  - count!=8 (short, or overflow at 9): rx_err=1 for one cycle; no ack; held registers unchanged.
- Back-to-back frames: START may arrive in the cycle immediately after END. The ack of the previous frame still fires in that cycle, and the new frame is received normally.
- Latency: END at edge n gives ack, rx_valid and the new rx_* visible after edge n+1.
- ack, rx_valid and rx_err are never high in two consecutive cycles from the same event.
- ack and rx_err are mutually exclusive.

Decomposition:
- Package fcp6_pkg holds:
  - ctrl encodings CTRL_IDLE, CTRL_START, CTRL_DATA, CTRL_END;
  - FRAME_SYMS=8;
  - BCAST_ADDR=4'hF;
  - rx state enum {RX_IDLE, RX_RECV}.
- Sub-module fcp6_deser: a 16-bit shift register with a 4-bit saturating symbol counter, controlled by clear and shift_en. fcp6_rx contains the FSM, the timeout counter, the address check and the output registers.

Test Plan:
- Valid frame: START, DATA 0,3,1,2,2,2,3,3 (header 8'h36, data 8'hAF), END, with ADDR=3 -> ack and rx_valid high one cycle after END; rx_header=8'h36, rx_data=8'hAF; rx_err stays 0.
- Broadcast and mismatch:
  - header 8'hF1 -> accepted with ack.
  - header 8'h51 -> no ack, no rx_valid, no rx_err; rx_header stays at its previous value.
- Framing errors:
  - END after 6 DATA symbols -> rx_err pulse, no ack.
  - 9 DATA symbols then END -> rx_err pulse, no ack.
- Stall and timeout:
  - 3 IDLE cycles after the 4th DATA, then the rest of the frame -> accepted normally.
  - 16 IDLE cycles after the 4th DATA -> rx_err pulse, busy drops, a later END is ignored.
- Restart and reset:
  - START after the 5th DATA -> rx_err pulse; the following complete frame is accepted.
  - rst asserted after the 3rd DATA -> all outputs 0 next cycle, no rx_err, a subsequent valid frame is accepted.
- Back-to-back: two valid frames with START directly after END -> two ack pulses; each rx_header/rx_data matches its own frame.
